tmr0_peripheral: RTL and testbench
==================================

// Module: tmr0_peripheral
// PURPOSE
//  Timer0 + OPTION_REG peripheral on the core's external peripheral bus; consumes the core's extern_peripherals_* signals.
//  8-bit TMR0 counter, OPTION_REG, 8-bit prescaler and a T0IF overflow pulse for INTCON.
//  Read data is zero when the block is not addressed, so the top level can OR it with other peripherals.
// PARAMETERS
//  CLKS_PER_INSTR  4  clk cycles per instruction cycle; sets the internal tick period
// PORTS
//  clk                          in   1  core clock
//  rst                          in   1  asynchronous, active-high reset
//  extern_peripherals_addr      in   9  register-file address from the core
//  extern_peripherals_data_in   in   8  write data (ALU output)
//  extern_peripherals_wr_en     in   1  one-clk write strobe; qualifies data_in at addr
//  extern_peripherals_data_out  out  8  read data; 0x00 when not selected
//  periph_sel                   out  1  addr hits TMR0 or OPTION_REG
//  t0if_set                     out  1  one-clk pulse on TMR0 0xFF->0x00 wrap
//  t0cki                        in   1  external clock pin; asynchronous; used only with the macro
// BEHAVIOUR
//  Reset: TMR0=0x00, OPTION=0xFF, prescaler=0, phase=0, inhibit=0, t0if_set=0.
//  Decode: TMR0 at 0x001/0x101; OPTION at 0x081/0x181.
//  Read path is combinational from current register values.
//  Instruction tick: a free-running counter 0..CLKS_PER_INSTR-1 pulses inst_tick when the count is CLKS_PER_INSTR-1.
//  OPTION bits: [7:6] unused (stored); [5] T0CS; [4] T0SE; [3] PSA; [2:0] PS.
//  Source tick: inst_tick, or the synchronised t0cki edge when T0CS=1 (macro only).
//  Prescaler:
//    - PSA=1: every source tick increments TMR0.
//    - PSA=0: 8-bit prescaler counts source ticks and increments TMR0 when it reaches 2^(PS+1)-1, then returns to 0.
//  Ratio: PS=0 gives 1:2; PS=7 gives 1:256.
//  Write to TMR0 (wr_en with a hit):
//    - TMR0 <= data_in next clk; prescaler cleared.
//    - inhibit counter loaded with 2; TMR0 increments are suppressed until 2 further inst_ticks have elapsed.
//  Write to OPTION: takes effect next clk; prescaler and TMR0 untouched.
//  Overflow: increment from 0xFF gives 0x00 and asserts t0if_set in the same clk as the wrap; no other pulse.
//  Simultaneous TMR0 write and increment: the write wins; no t0if_set even if TMR0 was 0xFF.
//  wr_en to an unmapped addr: ignored. Reset mid-count: all state returns to reset values immediately.
// CONFIGURATION
//  Macro TMR0_EXT_CLK_EN.
//  Defined:
//    - t0cki passes through a 2-FF synchroniser plus an edge register.
//    - T0SE=0 selects the rising edge; T0SE=1 selects the falling edge.
//    - When T0CS=1 the detected edge is the source tick; a pin edge reaches the prescaler 3 clk later.
//  Undefined:
//    - t0cki is ignored and T0CS is stored and readable but has no effect.
//    - The source is always inst_tick. Note that the reset value of OPTION sets T0CS=1.
// STRUCTURE
//  memory_map.vh holds ADDR_TMR0, ADDR_TMR0_B1, ADDR_OPTION_REG, ADDR_OPTION_REG_B1.
//  The same header holds the OPTION bit indices (OPT_T0CS, OPT_T0SE, OPT_PSA, OPT_PS_MSB/LSB).
//  Sub-module tmr0_prescaler: inputs tick, clr, psa, ps[2:0]; output inc_pulse; holds the 8-bit count.
// TESTING
//  1. Reset, then write OPTION=0x08 (PSA=1, internal), TMR0=0x00.
//     -> TMR0 reads 0x00 for 2 inst_ticks, then increments once per 4 clk.
//  2. OPTION=0x00 (1:2), TMR0=0xFE.
//     -> after inhibit, 0xFF at 2 inst_ticks, 0x00 at 4 with a single 1-clk t0if_set.
//  3. Write TMR0=0x55 in the clk an increment from 0xFF would occur.
//     -> TMR0=0x55 and t0if_set stays 0.
//  4. OPTION=0x07 (1:256): count 255 inst_ticks -> no increment; the 256th -> TMR0+1.
//     Writing TMR0 mid-count clears the prescaler.
//  5. Read 0x081 -> 0xFF after reset; read 0x005 -> 0x00 with periph_sel=0.
//     wr_en to 0x005 changes nothing.
//  6. TMR0_EXT_CLK_EN defined, OPTION=0x28 (T0CS=1, rising): 3 t0cki rising edges -> TMR0=3.
//     Each increment follows its edge by 3 clk; with T0SE=1 falling edges count instead.

Source files
------------

// File: rtl/tmr0_pkg.sv
// rtl/tmr0_pkg.sv - TMR0/OPTION_REG memory map, OPTION bit indices and prescaler helper
package tmr0_pkg;

    localparam logic [8:0] ADDR_TMR0          = 9'h001;
    localparam logic [8:0] ADDR_TMR0_B1       = 9'h101;
    localparam logic [8:0] ADDR_OPTION_REG    = 9'h081;
    localparam logic [8:0] ADDR_OPTION_REG_B1 = 9'h181;

    localparam int OPT_T0CS   = 5;
    localparam int OPT_T0SE   = 4;
    localparam int OPT_PSA    = 3;
    localparam int OPT_PS_MSB = 2;
    localparam int OPT_PS_LSB = 0;

    localparam logic [7:0] OPTION_RESET = 8'hFF;

    // Terminal prescaler count for a PS setting: 2^(PS+1)-1
    function automatic logic [7:0] ps_limit(input logic [2:0] ps);
        return 8'hFF >> (3'd7 - ps);
    endfunction

endpackage

// File: rtl/tmr0_prescaler.sv
// rtl/tmr0_prescaler.sv - 8-bit TMR0 prescaler, divides source ticks by 2^(PS+1) or bypasses
module tmr0_prescaler
    import tmr0_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clr,
    input  logic       psa,
    input  logic [2:0] ps,
    output logic       inc_pulse
);

    logic [7:0] count;
    logic       at_limit;

    assign at_limit  = (count == ps_limit(ps));
    assign inc_pulse = tick && (psa || at_limit);

    // Count source ticks while assigned to TMR0; wrap to 0 on the terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'h00;
        end else if (clr) begin
            count <= 8'h00;
        end else if (tick && !psa) begin
            count <= at_limit ? 8'h00 : count + 8'h01;
        end
    end

endmodule

// File: rtl/tmr0_peripheral.sv
// rtl/tmr0_peripheral.sv - Timer0 + OPTION_REG peripheral; TMR0_EXT_CLK_EN enables the t0cki source
module tmr0_peripheral
    import tmr0_pkg::*;
#(
    parameter int CLKS_PER_INSTR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] extern_peripherals_addr,
    input  logic [7:0] extern_peripherals_data_in,
    input  logic       extern_peripherals_wr_en,
    output logic [7:0] extern_peripherals_data_out,
    output logic       periph_sel,
    output logic       t0if_set,
    input  logic       t0cki
);

    localparam int PW = (CLKS_PER_INSTR > 1) ? $clog2(CLKS_PER_INSTR) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_INSTR - 1);

    logic [7:0]    tmr0;
    logic [7:0]    option;
    logic [PW-1:0] phase;
    logic [1:0]    inhibit;
    logic          inst_tick;
    logic          src_tick;
    logic          gated_tick;
    logic          inc_pulse;
    logic          sel_tmr0;
    logic          sel_option;
    logic          wr_tmr0;
    logic          wr_option;

    assign sel_tmr0   = (extern_peripherals_addr == ADDR_TMR0) ||
                        (extern_peripherals_addr == ADDR_TMR0_B1);
    assign sel_option = (extern_peripherals_addr == ADDR_OPTION_REG) ||
                        (extern_peripherals_addr == ADDR_OPTION_REG_B1);
    assign periph_sel = sel_tmr0 || sel_option;
    assign wr_tmr0    = extern_peripherals_wr_en && sel_tmr0;
    assign wr_option  = extern_peripherals_wr_en && sel_option;
    assign inst_tick  = (phase == PHASE_LAST);

    // Read mux returns zero when unaddressed so the top level can OR peripherals together
    always_comb begin
        extern_peripherals_data_out = 8'h00;
        if (sel_tmr0) begin
            extern_peripherals_data_out = tmr0;
        end else if (sel_option) begin
            extern_peripherals_data_out = option;
        end
    end

    // Free-running instruction-cycle phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (inst_tick) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

`ifdef TMR0_EXT_CLK_EN
    logic t0cki_s1;
    logic t0cki_s2;
    logic t0cki_prev;
    logic ext_edge;

    // Two-flop synchroniser plus edge register for the asynchronous pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t0cki_s1   <= 1'b0;
            t0cki_s2   <= 1'b0;
            t0cki_prev <= 1'b0;
        end else begin
            t0cki_s1   <= t0cki;
            t0cki_s2   <= t0cki_s1;
            t0cki_prev <= t0cki_s2;
        end
    end

    assign ext_edge = option[OPT_T0SE] ? (!t0cki_s2 && t0cki_prev)
                                       : (t0cki_s2 && !t0cki_prev);
    assign src_tick = option[OPT_T0CS] ? ext_edge : inst_tick;
`else
    logic unused_t0cki;
    assign unused_t0cki = t0cki;
    assign src_tick     = inst_tick;
`endif

    // Source ticks are withheld from the prescaler while a TMR0 write is settling
    assign gated_tick = src_tick && (inhibit == 2'd0);

    // Post-write inhibit: suppress counting for the next two instruction ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit <= 2'd0;
        end else if (wr_tmr0) begin
            inhibit <= 2'd2;
        end else if (inst_tick && (inhibit != 2'd0)) begin
            inhibit <= inhibit - 2'd1;
        end
    end

    tmr0_prescaler u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .tick      (gated_tick),
        .clr       (wr_tmr0),
        .psa       (option[OPT_PSA]),
        .ps        (option[OPT_PS_MSB:OPT_PS_LSB]),
        .inc_pulse (inc_pulse)
    );

    // OPTION register write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            option <= OPTION_RESET;
        end else if (wr_option) begin
            option <= extern_peripherals_data_in;
        end
    end

    // TMR0 count with write priority; overflow pulse coincides with the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr0     <= 8'h00;
            t0if_set <= 1'b0;
        end else if (wr_tmr0) begin
            tmr0     <= extern_peripherals_data_in;
            t0if_set <= 1'b0;
        end else if (inc_pulse) begin
            tmr0     <= tmr0 + 8'h01;
            t0if_set <= (tmr0 == 8'hFF);
        end else begin
            t0if_set <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmr0_peripheral.sv
// tb/tb_tmr0_peripheral.sv - table-driven self-checking bench for tmr0_peripheral
module tb_tmr0_peripheral;

    logic       clk;
    logic       rst;
    logic [8:0] addr;
    logic [7:0] data_in;
    logic       wr_en;
    logic [7:0] data_out;
    logic       periph_sel;
    logic       t0if_set;
    logic       t0cki;

    int n_checks;
    int n_fails;

    typedef struct {
        logic       wr;
        logic [8:0] addr;
        logic [7:0] data;
        logic [7:0] exp_do;
        logic       exp_sel;
        logic       exp_t0if;
    } vec_t;

    vec_t vecs[$];

    tmr0_peripheral #(.CLKS_PER_INSTR(4)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .extern_peripherals_addr     (addr),
        .extern_peripherals_data_in  (data_in),
        .extern_peripherals_wr_en    (wr_en),
        .extern_peripherals_data_out (data_out),
        .periph_sel                  (periph_sel),
        .t0if_set                    (t0if_set),
        .t0cki                       (t0cki)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic wr, input logic [8:0] a, input logic [7:0] d,
                                input logic [7:0] e_do, input logic e_sel, input logic e_t0if);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d;
        v.exp_do = e_do; v.exp_sel = e_sel; v.exp_t0if = e_t0if;
        vecs.push_back(v);
    endfunction

    function automatic void rd(input int n, input logic [8:0] a, input logic [7:0] e_do);
        for (int k = 0; k < n; k++) add(1'b0, a, 8'h00, e_do, 1'b1, 1'b0);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1; wr_en = 1'b0; addr = 9'h000; data_in = 8'h00; t0cki = 1'b0;

        // Entry j is applied for the (j+1)th clock after reset release; inst_tick edges are j = 3, 7, 11, ...
        // Test 1: PSA=1, TMR0=0 -> two inhibited ticks, then +1 per instruction
        add(1'b1, 9'h081, 8'h08, 8'h08, 1'b1, 1'b0);
        add(1'b1, 9'h001, 8'h00, 8'h00, 1'b1, 1'b0);
        rd(9, 9'h001, 8'h00);
        rd(4, 9'h001, 8'h01);
        rd(2, 9'h001, 8'h02);
        // Test 2: 1:2 prescale from 0xFE; single wrap pulse at j=39
        add(1'b1, 9'h081, 8'h00, 8'h00, 1'b1, 1'b0);
        add(1'b1, 9'h001, 8'hFE, 8'hFE, 1'b1, 1'b0);
        rd(12, 9'h001, 8'hFE);
        rd(8, 9'h001, 8'hFF);
        add(1'b0, 9'h001, 8'h00, 8'h00, 1'b1, 1'b1);
        rd(2, 9'h001, 8'h00);
        // Test 3: write lands in the same clk as the 0xFF->0x00 increment
        add(1'b1, 9'h001, 8'hFF, 8'hFF, 1'b1, 1'b0);
        rd(12, 9'h001, 8'hFF);
        add(1'b1, 9'h001, 8'h55, 8'h55, 1'b1, 1'b0);
        rd(1, 9'h001, 8'h55);
        // Test 4: 1:256 via bank-1 aliases; 256th counted tick at j=1087
        add(1'b1, 9'h181, 8'h07, 8'h07, 1'b1, 1'b0);
        add(1'b1, 9'h101, 8'h10, 8'h10, 1'b1, 1'b0);
        rd(1028, 9'h001, 8'h10);
        rd(101, 9'h001, 8'h11);
        // Mid-count write with 25 ticks in the prescaler: full 256 ticks needed again
        add(1'b1, 9'h001, 8'h20, 8'h20, 1'b1, 1'b0);
        rd(1030, 9'h001, 8'h20);
        rd(1, 9'h001, 8'h21);
        // Test 5: unmapped read and write
        add(1'b0, 9'h005, 8'h00, 8'h00, 1'b0, 1'b0);
        add(1'b1, 9'h005, 8'hAA, 8'h00, 1'b0, 1'b0);
        rd(1, 9'h001, 8'h21);
        rd(1, 9'h081, 8'h07);
        rd(1, 9'h101, 8'h21);

        repeat (3) @(posedge clk);
        @(negedge clk);
        addr = 9'h081; #1;
        check8("reset_option", data_out, 8'hFF);
        check1("reset_sel_option", periph_sel, 1'b1);
        addr = 9'h001; #1;
        check8("reset_tmr0", data_out, 8'h00);
        check1("reset_t0if", t0if_set, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            addr = vecs[i].addr; data_in = vecs[i].data; wr_en = vecs[i].wr;
            @(posedge clk); #1;
            check8($sformatf("vec%0d_data", i), data_out, vecs[i].exp_do);
            check1($sformatf("vec%0d_sel", i), periph_sel, vecs[i].exp_sel);
            check1($sformatf("vec%0d_t0if", i), t0if_set, vecs[i].exp_t0if);
            @(negedge clk);
        end
        wr_en = 1'b0;

        // Asynchronous reset mid-count returns everything to reset values at once
        @(posedge clk); #2;
        rst = 1'b1; addr = 9'h081; #1;
        check8("async_rst_option", data_out, 8'hFF);
        addr = 9'h001; #1;
        check8("async_rst_tmr0", data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // OPTION reset value has T0CS=1, but the internal tick still drives TMR0 (PSA=1)
        repeat (3) @(posedge clk); #1;
        check8("t0cs_ignored_pre", data_out, 8'h00);
        @(posedge clk); #1;
        check8("t0cs_ignored_inc", data_out, 8'h01);
        check1("t0cs_ignored_t0if", t0if_set, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
